// File: rtl/mem_io_router.sv
// mem_io_router: byte-bus router between the CPU core, a 128 KiB synchronous
// RAM and a small IO window (UART TX FIFO + RX holding register).
// Optional feature macro: MEM_ROUTER_RX_EN builds the RX holding register;
// when undefined, rx_ready is tied low and DATA reads return 0x00.
module mem_io_router #(
  parameter int unsigned IO_FIFO_DEPTH  = 8,
  parameter int unsigned RAM_ADDR_WIDTH = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               cpu_addr,
  input  logic [7:0]                cpu_dout,
  input  logic                      cpu_wr,
  output logic [7:0]                cpu_din,
  output logic                      cpu_rdy,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]                ram_dout,
  output logic                      ram_wr,
  input  logic [7:0]                ram_din,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready
);

  localparam int unsigned PTR_W = $clog2(IO_FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] DATA_ADDR = 32'h0003_0000;
  localparam logic [31:0] STAT_ADDR = 32'h0003_0004;

  logic             io, io_data, io_stat;
  logic             tx_full, push, pop;
  logic [CNT_W-1:0] tx_count;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [7:0]       fifo_mem [IO_FIFO_DEPTH];
  logic             src_io;
  logic [7:0]       io_rdata, io_rdata_nxt;
  logic             rx_full;
  logic [7:0]       data_val;

  // Address decode and core handshake
  assign io      = cpu_addr[17];
  assign io_data = (cpu_addr == DATA_ADDR);
  assign io_stat = (cpu_addr == STAT_ADDR);
  assign tx_full = (tx_count == CNT_W'(IO_FIFO_DEPTH));
  assign cpu_rdy = !rst && !(io_data && cpu_wr && tx_full);

  // RAM side is a straight pass-through, write gated by decode and stall
  assign ram_addr = cpu_addr[RAM_ADDR_WIDTH-1:0];
  assign ram_dout = cpu_dout;
  assign ram_wr   = cpu_wr && !io && cpu_rdy;

  // TX FIFO control; full is taken from the registered count so a pop
  // never unblocks a push in the same cycle
  assign push     = io_data && cpu_wr && !tx_full && !rst;
  assign tx_valid = (tx_count != '0);
  assign pop      = tx_valid && tx_ready;
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   tx_count <= tx_count + CNT_W'(1);
        2'b01:   tx_count <= tx_count - CNT_W'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cpu_dout;
  end

`ifdef MEM_ROUTER_RX_EN
  logic [7:0] rx_byte;
  logic       rx_load, data_rd;

  assign rx_ready = !rx_full && !rst;
  assign rx_load  = rx_valid && rx_ready;
  assign data_rd  = io_data && !cpu_wr && cpu_rdy;
  assign data_val = rx_full ? rx_byte : 8'h00;

  // RX holding register: a DATA read empties it, a load refills it
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_full <= 1'b0;
      rx_byte <= 8'h00;
    end else begin
      if (data_rd) rx_full <= 1'b0;
      if (rx_load) begin
        rx_full <= 1'b1;
        rx_byte <= rx_data;
      end
    end
  end
`else
  logic unused_rx;

  assign unused_rx = ^{rx_data, rx_valid};
  assign rx_ready  = 1'b0;
  assign rx_full   = 1'b0;
  assign data_val  = 8'h00;
`endif

  // IO read mux for the current address
  always_comb begin
    io_rdata_nxt = 8'h00;
    if (io_data)      io_rdata_nxt = data_val;
    else if (io_stat) io_rdata_nxt = {6'b0, rx_full, tx_full};
  end

  // Read-return pipeline, frozen while the core is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      src_io   <= 1'b1;
      io_rdata <= 8'h00;
    end else if (cpu_rdy) begin
      src_io   <= io;
      io_rdata <= io_rdata_nxt;
    end
  end

  assign cpu_din = src_io ? io_rdata : ram_din;

endmodule

// File: tb/tb_mem_io_router.sv
// Self-checking bench for mem_io_router: directed test-plan sequences followed
// by randomized traffic, all compared against a queue-based reference model.
module tb_mem_io_router;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] A_DATA = 32'h0003_0000;
  localparam logic [31:0] A_STAT = 32'h0003_0004;
`ifdef MEM_ROUTER_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic [16:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_io_router #(.IO_FIFO_DEPTH(DEPTH), .RAM_ADDR_WIDTH(17)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
    .cpu_din(cpu_din), .cpu_rdy(cpu_rdy),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  // Board RAM: synchronous, read-first, one cycle latency
  logic [7:0] env_ram [131072];
  always @(posedge clk) begin
    if (ram_wr) env_ram[ram_addr] <= ram_dout;
    ram_din <= env_ram[ram_addr];
  end

  // Reference model state
  logic [7:0] mdl_ram [131072];
  logic [7:0] tq [$];
  bit         m_rx_full = 1'b0;
  logic [7:0] m_rx_byte = 8'h00;
  bit         m_din_chk = 1'b0;
  logic [7:0] m_din_exp = 8'h00;
  bit         m_after_rst = 1'b0;
  bit         m_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive, check against the model mid-cycle, advance the model
  task automatic cycle(input logic r, input logic [31:0] a, input logic [7:0] d,
                       input logic w, input logic txr, input logic rxv,
                       input logic [7:0] rxd);
    bit         is_io, is_data, is_stat, full, e_rdy, e_ramwr, e_rxr, do_pop;
    logic [7:0] rdval;
    rst = r; cpu_addr = a; cpu_dout = d; cpu_wr = w;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    #4;
    is_io   = a[17];
    is_data = (a == A_DATA);
    is_stat = (a == A_STAT);
    full    = (tq.size() == DEPTH);
    e_rdy   = !r && !(is_data && w && full);
    e_ramwr = w && !is_io && e_rdy;
    e_rxr   = RX_EN && !m_rx_full && !r;
    check("cpu_rdy", cpu_rdy, e_rdy);
    check("ram_wr", ram_wr, e_ramwr);
    check("rx_ready", rx_ready, e_rxr);
    check("tx_valid", tx_valid, tq.size() > 0);
    if (tq.size() > 0)  check("tx_data", tx_data, tq[0]);
    else if (m_after_rst) check("tx_data_rst", tx_data, 8'h00);
    if (m_din_chk) check("cpu_din", cpu_din, m_din_exp);

    if (r) begin
      tq.delete();
      m_rx_full = 1'b0;
      m_din_chk = 1'b1;
      m_din_exp = 8'h00;
    end else begin
      do_pop = (tq.size() > 0) && txr;
      if (is_data && !w) rdval = (RX_EN && m_rx_full) ? m_rx_byte : 8'h00;
      else if (is_stat)  rdval = {6'b0, RX_EN && m_rx_full, full};
      else if (is_io)    rdval = 8'h00;
      else               rdval = mdl_ram[a[16:0]];
      m_din_chk = e_rdy && !w;
      m_din_exp = rdval;
      if (do_pop) void'(tq.pop_front());
      if (is_data && w && !full) tq.push_back(d);
      if (RX_EN) begin
        if (is_data && !w && e_rdy) m_rx_full = 1'b0;
        if (rxv && e_rxr) begin
          m_rx_full = 1'b1;
          m_rx_byte = rxd;
        end
      end
      if (e_ramwr) mdl_ram[a[16:0]] = d;
    end
    m_after_rst = r;
    m_rdy = e_rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] la;
    logic [7:0]  ld;
    logic        lw;
    int          sel;
    for (int i = 0; i < 131072; i++) begin
      env_ram[i] = 8'h00;
      mdl_ram[i] = 8'h00;
    end
    rst = 1'b1; cpu_addr = '0; cpu_dout = '0; cpu_wr = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    @(posedge clk);
    #1;
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("reset_din", cpu_din, 8'h00);

    // RAM write then read
    cycle(0, 32'h10, 8'hA5, 1, 0, 0, 0);
    cycle(0, 32'h10, 8'h00, 0, 0, 0, 0);
    check("ram_rd_a5", cpu_din, 8'hA5);
    cycle(0, 32'h0, 8'h00, 0, 0, 0, 0);

    // TX fill with the UART not ready, then stall on the ninth byte
    for (int i = 1; i <= 8; i++) cycle(0, A_DATA, 8'(i), 1, 0, 0, 0);
    cycle(0, A_STAT, 0, 0, 0, 0, 0);
    check("status_full", cpu_din, 8'h01);
    for (int i = 0; i < 3; i++) cycle(0, A_DATA, 8'h09, 1, 0, 0, 0);
    check("stall_rdy", cpu_rdy, 1'b0);

    // Drain: the held write completes after the first pop
    cycle(0, A_DATA, 8'h09, 1, 1, 0, 0);
    check("unstall_rdy", cpu_rdy, 1'b1);
    cycle(0, A_DATA, 8'h09, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 32'h0, 0, 0, 1, 0, 0);
    check("drained", tx_valid, 1'b0);

`ifdef MEM_ROUTER_RX_EN
    // RX byte captured, read once, then empty
    cycle(0, 32'h0, 0, 0, 0, 1, 8'h5A);
    cycle(0, A_STAT, 0, 0, 0, 0, 0);
    check("rx_status", cpu_din, 8'h02);
    cycle(0, A_DATA, 0, 0, 0, 0, 0);
    check("rx_read1", cpu_din, 8'h5A);
    cycle(0, A_DATA, 0, 0, 0, 0, 0);
    check("rx_read2", cpu_din, 8'h00);
    check("rx_ready_back", rx_ready, 1'b1);
    cycle(0, 32'h0, 0, 0, 0, 0, 0);
`else
    // No RX storage: incoming bytes are refused and reads return zero
    cycle(0, A_DATA, 0, 0, 0, 1, 8'h33);
    check("norx_data", cpu_din, 8'h00);
    cycle(0, A_STAT, 0, 0, 0, 1, 8'h33);
    cycle(0, A_DATA, 0, 0, 0, 1, 8'h33);
    check("norx_status", cpu_din, 8'h00);
    check("norx_ready", rx_ready, 1'b0);
    cycle(0, 32'h0, 0, 0, 0, 0, 0);
`endif

    // Reset with three queued TX bytes
    for (int i = 0; i < 3; i++) cycle(0, A_DATA, 8'hC0 + 8'(i), 1, 0, 0, 0);
    cycle(1, 32'h0, 0, 0, 0, 0, 0);
    check("rst_txv", tx_valid, 1'b0);
    check("rst_din", cpu_din, 8'h00);
    cycle(0, 32'h0, 0, 0, 0, 0, 0);

    // Randomized traffic; a stalled core holds its bus
    la = '0; ld = '0; lw = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (m_rdy) begin
        sel = int'($urandom_range(0, 9));
        case (sel)
          0, 1, 2: la = 32'($urandom_range(0, 15));
          3, 4, 5: la = A_DATA;
          6:       la = A_STAT;
          7:       la = 32'h0003_0008;
          default: la = 32'h0002_0010;
        endcase
        ld = 8'($urandom);
        lw = 1'($urandom);
      end
      cycle(($urandom_range(0, 63) == 0), la, ld, lw,
            ($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_io_router.md
# mem_io_router

Byte-bus router between `CPU_core` and the board: it decodes each core address into either the 128 KiB synchronous RAM or a memory-mapped IO window. IO writes go to a UART TX FIFO and IO reads come from an RX holding register. When the TX FIFO cannot accept a byte, the router stalls the core through its `rdy` input. It sits directly downstream of the core's `addr`/`dout`/`wr`/`din` pins and presents the same 1-cycle read latency for both RAM and IO.

## Interface
Parameters:
- `IO_FIFO_DEPTH`, default 8: TX FIFO entries; power of two, ≥2.
- `RAM_ADDR_WIDTH`, default 17: RAM address bits.

Ports:
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_addr` in 32: core byte address.
- `cpu_dout` in 8: core write data.
- `cpu_wr` in 1: core write strobe (1 = write, 0 = read).
- `cpu_din` out 8: read data to core, valid the cycle after the address.
- `cpu_rdy` out 1: core advance enable; 0 means the core must hold `addr`/`dout`/`wr`.
- `ram_addr` out `RAM_ADDR_WIDTH`: equals `cpu_addr[RAM_ADDR_WIDTH-1:0]`.
- `ram_dout` out 8: equals `cpu_dout`.
- `ram_wr` out 1: RAM write enable.
- `ram_din` in 8: RAM read data, 1 cycle after `ram_addr`.
- `tx_data` out 8: head byte of the TX FIFO.
- `tx_valid` out 1: TX FIFO non-empty.
- `tx_ready` in 1: UART accepts `tx_data` when `tx_valid && tx_ready`.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: router accepts `rx_data` this cycle.

## Operation
- Address decode:
  - IO when `cpu_addr[17]=1`, otherwise RAM.
  - IO registers:
    - DATA at `0x30000`.
    - STATUS at `0x30004`.
    - All other IO addresses read 0x00 and ignore writes.
- `ram_wr = cpu_wr && !io && cpu_rdy && !rst`.
- `cpu_rdy = !rst && !(io_data && cpu_wr && tx_full)`. It is combinational.
- TX FIFO:
  - Push `cpu_dout` on a DATA write when `!tx_full`.
  - Pop when `tx_valid && tx_ready`.
  - Full/empty are computed from the registered occupancy count. A push while full is blocked even if a pop happens in the same cycle. Push and pop in the same cycle when neither full nor empty keeps the count unchanged.
  - Read/write pointers wrap modulo `IO_FIFO_DEPTH`; the count is `log2(DEPTH)+1` bits.
- RX holding register (1 byte plus a full flag):
  - `rx_ready = !rx_full && !rst`.
  - Load on `rx_valid && rx_ready`.
  - Every cycle with `cpu_addr==0x30000`, `!cpu_wr` and `cpu_rdy` is a DATA read:
    - It returns the held byte if `rx_full`, else 0x00.
    - It clears `rx_full`.
  - A DATA read and an RX load in the same cycle while empty: the read returns 0x00 and the byte is loaded.
- STATUS read value: `{6'b0, rx_full, tx_full}`.
- Read data path:
  - A registered `src_io` flag and `io_rdata` byte are captured on every cycle with `cpu_rdy=1`.
  - `cpu_din = src_io ? io_rdata : ram_din`.
  - When `cpu_rdy=0`, `src_io`/`io_rdata` hold.

## Timing
- Reset values:
  - `cpu_din`=0x00 (`src_io`=1, `io_rdata`=0).
  - `cpu_rdy`=0, `ram_wr`=0.
  - `tx_valid`=0, `tx_data`=0x00.
  - `rx_ready`=0.
  - FIFO count/pointers 0, `rx_full`=0.
- Read latency is 1 cycle for RAM and IO: address in cycle N gives `cpu_din` in N+1.
- Stall: a blocked TX write keeps `cpu_rdy`=0 until the first cycle after a pop leaves the FIFO not full. The write is then pushed in that cycle.
- Reset mid-operation: FIFO contents and the RX byte are discarded, and `ram_wr` is suppressed in the reset cycle.
- `tx_data`/`tx_valid` change only on clock edges, since they come from registered state.

## Configuration
- `MEM_ROUTER_RX_EN` defined: the RX holding register is built as above.
- `MEM_ROUTER_RX_EN` undefined:
  - No RX storage; `rx_ready` is tied to 0 and `rx_data` is ignored.
  - DATA reads return 0x00.
  - STATUS bit 1 is constant 0.
  - TX path and RAM path are unchanged.

## Test plan
- RAM write then read: write 0xA5 to `0x00010`, then read `0x00010` → `ram_wr`=1 for one cycle, and `cpu_din`=0xA5 the cycle after the read address.
- TX fill with `tx_ready`=0: 8 DATA writes 0x01..0x08 → `cpu_rdy` stays 1, STATUS reads 0x01; a 9th write 0x09 → `cpu_rdy`=0 and is held.
- Drain with `tx_ready`=1: bytes appear in the order 0x01..0x09; `cpu_rdy` returns to 1 the cycle after the first pop, and 0x09 is pushed exactly once.
- RX: `rx_valid` with 0x5A → `rx_ready` drops and STATUS=0x02; a DATA read returns 0x5A one cycle later, a second read returns 0x00, and `rx_ready` goes back to 1.
- Reset with 3 TX bytes queued: `rst` for 1 cycle → `tx_valid`=0, `cpu_din`=0x00, `cpu_rdy`=0 during reset and 1 after.
- Without `MEM_ROUTER_RX_EN`: hold `rx_valid`=1 with 0x33 → `rx_ready` stays 0, DATA reads return 0x00, STATUS bit 1 stays 0.
